code_set_detector: RTL and testbench

//  Clocked, parametrised successor to the 4-input combinational code detector.
//  - Each valid WIDTH-bit input code is checked against a run-time programmable membership table (2**WIDTH bits).
//  - Outputs: a registered match flag, a pulse-stretched LED and a saturating hit counter.
//  - Sits between the switch/code input logic and the board LED driver.

---
 rtl/code_set_detector_pkg.sv | 13 +
 rtl/code_set_detector_if.sv | 27 ++
 rtl/code_set_detector_led_stretcher.sv | 50 +++++
 rtl/code_set_detector.sv | 65 ++++++
 tb/tb_code_set_detector.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/code_set_detector_pkg.sv
// Shared constants and stretch-state encoding for the code set detector and its indicators.
package code_det_pkg;

  localparam int CSD_WIDTH   = 4;
  localparam int CSD_STRETCH = 8;
  localparam int CSD_CNT_W   = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } stretch_st_e;

endpackage

// File: rtl/code_set_detector_if.sv
// Code input, table configuration and indicator outputs of the code set detector.
interface code_set_detector_if import code_det_pkg::*; #(
  parameter int WIDTH = CSD_WIDTH,
  parameter int CNT_W = CSD_CNT_W
);

  logic             in_valid;
  logic [WIDTH-1:0] in_code;
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_addr;
  logic             cfg_bit;
  logic             clr_count;
  logic             match;
  logic             led;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output in_valid, in_code, cfg_we, cfg_addr, cfg_bit, clr_count,
    input  match, led, hit_count
  );

  modport slave (
    input  in_valid, in_code, cfg_we, cfg_addr, cfg_bit, clr_count,
    output match, led, hit_count
  );

endinterface

// File: rtl/code_set_detector_led_stretcher.sv
// Holds led high for exactly STRETCH cycles after the last trig cycle; retrigger reloads with no gap.
//   state   | meaning
//   S_IDLE  | led off, waiting for trig
//   S_HOLD  | led on, r_cnt counts down the remaining hold cycles
module led_stretcher import code_det_pkg::*; #(
  parameter int STRETCH = CSD_STRETCH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic led
);

  localparam int              CW     = $clog2(STRETCH + 1);
  localparam logic [CW-1:0]   RELOAD = CW'(STRETCH - 1);
  localparam logic [0:0]      S_IDLE = ST_IDLE;
  localparam logic [0:0]      S_HOLD = ST_HOLD;

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (trig) begin
            r_state <= S_HOLD;
            r_cnt   <= RELOAD;
          end
        end
        default: begin
          if (trig) begin
            r_cnt <= RELOAD;
          end else if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
      endcase
    end
  end

  // Decoded from the state flop so an asynchronous reset drops led immediately.
  assign led = (r_state == S_HOLD);

endmodule

// File: rtl/code_set_detector.sv
// Registered membership lookup of valid codes against a programmable bit table,
// with a stretched LED indicator and a saturating hit counter.
module code_set_detector import code_det_pkg::*; #(
  parameter int                    WIDTH      = CSD_WIDTH,
  parameter logic [(1<<WIDTH)-1:0] TABLE_INIT = '0,
  parameter int                    STRETCH    = CSD_STRETCH,
  parameter int                    CNT_W      = CSD_CNT_W
) (
  input logic                clk,
  input logic                rst_n,
  code_set_detector_if.slave bus
);

  localparam int DEPTH = 1 << WIDTH;

  logic [DEPTH-1:0] r_table;
  logic             r_match;
  logic [CNT_W-1:0] r_hit;
  logic             w_lookup;
  logic             w_led;

  // Gated by in_valid so an unknown in_code never reaches the match flop.
  assign w_lookup = bus.in_valid ? r_table[bus.in_code] : 1'b0;

  // Lookup and write share the edge, so a same-cycle write is seen only by later lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_table <= TABLE_INIT;
    end else if (bus.cfg_we) begin
      r_table[bus.cfg_addr] <= bus.cfg_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match <= 1'b0;
    end else begin
      r_match <= w_lookup;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit <= '0;
    end else if (bus.clr_count) begin
      r_hit <= '0;
    end else if (r_match && (r_hit != {CNT_W{1'b1}})) begin
      r_hit <= r_hit + CNT_W'(1);
    end
  end

  led_stretcher #(
    .STRETCH (STRETCH)
  ) u_led (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (r_match),
    .led   (w_led)
  );

  assign bus.match     = r_match;
  assign bus.led       = w_led;
  assign bus.hit_count = r_hit;

endmodule

// File: tb/tb_code_set_detector.sv
// Directed bench for code_set_detector: vector table for lookup/write paths, hand sequences for stretch, saturation and reset.
module tb_code_set_detector;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  code_set_detector_if #(.WIDTH(4), .CNT_W(3)) bus ();

  code_set_detector #(
    .WIDTH      (4),
    .TABLE_INIT (16'h20AC),
    .STRETCH    (8),
    .CNT_W      (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] code;
    logic       we;
    logic [3:0] addr;
    logic       bitv;
    logic       clr;
    logic       m;
    logic       led;
    logic [2:0] hit;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input logic [3:0] code, input logic we,
                              input logic [3:0] addr, input logic bitv, input logic clr,
                              input logic m, input logic led, input logic [2:0] hit);
    vec_t t;
    t.v = v; t.code = code; t.we = we; t.addr = addr; t.bitv = bitv; t.clr = clr;
    t.m = m; t.led = led; t.hit = hit;
    vecs.push_back(t);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] code, input logic clr);
    bus.in_valid  = v;
    bus.in_code   = code;
    bus.clr_count = clr;
    bus.cfg_we    = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_code = '0; bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;   bus.cfg_bit = 1'b0; bus.clr_count = 1'b0;

    // Sweep with TABLE_INIT=20AC: members 2,3,5,7,13.
    //   v  code we addr bit clr | match led hit
    add(1, 0,  0, 0, 0, 0,  0, 0, 0);
    add(1, 1,  0, 0, 0, 0,  0, 0, 0);
    add(1, 2,  0, 0, 0, 0,  1, 0, 0);
    add(1, 3,  0, 0, 0, 0,  1, 1, 1);
    add(1, 4,  0, 0, 0, 0,  0, 1, 2);
    add(1, 5,  0, 0, 0, 0,  1, 1, 2);
    add(1, 6,  0, 0, 0, 0,  0, 1, 3);
    add(1, 7,  0, 0, 0, 0,  1, 1, 3);
    add(1, 8,  0, 0, 0, 0,  0, 1, 4);
    add(1, 9,  0, 0, 0, 0,  0, 1, 4);
    add(1, 10, 0, 0, 0, 0,  0, 1, 4);
    add(1, 11, 0, 0, 0, 0,  0, 1, 4);
    add(1, 12, 0, 0, 0, 0,  0, 1, 4);
    add(1, 13, 0, 0, 0, 0,  1, 1, 4);
    add(1, 14, 0, 0, 0, 0,  0, 1, 5);
    add(1, 15, 0, 0, 0, 0,  0, 1, 5);
    add(0, 2,  0, 0, 0, 0,  0, 1, 5);
    add(0, 3,  0, 0, 0, 0,  0, 1, 5);
    add(0, 5,  0, 0, 0, 0,  0, 1, 5);
    add(0, 7,  0, 0, 0, 0,  0, 1, 5);
    add(0, 13, 0, 0, 0, 0,  0, 1, 5);
    add(0, 2,  0, 0, 0, 0,  0, 1, 5);
    add(0, 3,  0, 0, 0, 0,  0, 0, 5);
    // Read-before-write on code 4, then the new bit is visible.
    add(1, 4,  1, 4, 1, 0,  0, 0, 5);
    add(1, 4,  0, 0, 0, 0,  1, 0, 5);
    add(0, 0,  0, 0, 0, 0,  0, 1, 6);

    repeat (2) @(posedge clk);
    #1;
    check("reset match", bus.match, 0);
    check("reset led", bus.led, 0);
    check("reset hit", bus.hit_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.in_valid  = vecs[i].v;
      bus.in_code   = vecs[i].code;
      bus.cfg_we    = vecs[i].we;
      bus.cfg_addr  = vecs[i].addr;
      bus.cfg_bit   = vecs[i].bitv;
      bus.clr_count = vecs[i].clr;
      step();
      check($sformatf("vec%0d match", i), bus.match, vecs[i].m);
      check($sformatf("vec%0d led", i), bus.led, vecs[i].led);
      check($sformatf("vec%0d hit", i), bus.hit_count, vecs[i].hit);
    end
    drive(0, 0, 0);

    // Single match: led high for exactly 8 cycles starting 2 cycles after in_valid.
    repeat (12) step();
    check("stretch idle led", bus.led, 0);
    drive(1, 2, 0);
    step();
    check("stretch e0 match", bus.match, 1);
    check("stretch e0 led", bus.led, 0);
    drive(0, 2, 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("single led k%0d", k), bus.led, (k <= 8) ? 1 : 0);
    end

    // Retrigger 5 cycles after the first match: no gap, ends 8 cycles after the second.
    drive(1, 5, 0);
    step();
    for (int k = 1; k <= 15; k++) begin
      drive((k == 5) ? 1'b1 : 1'b0, 4'd7, 1'b0);
      step();
      check($sformatf("retrig led k%0d", k), bus.led, (k <= 13) ? 1 : 0);
    end

    // Saturation at 7 with CNT_W=3, then clear wins over a same-cycle match.
    drive(0, 0, 1);
    step();
    check("clr idle hit", bus.hit_count, 0);
    for (int n = 0; n < 10; n++) begin
      drive(1, 3, 0);
      step();
      check($sformatf("sat hit n%0d", n), bus.hit_count, (n < 7) ? n : 7);
    end
    drive(1, 3, 1);
    step();
    check("clr vs match hit", bus.hit_count, 0);
    drive(1, 3, 0);
    step();
    check("post clr hit", bus.hit_count, 1);

    // Asynchronous reset mid-HOLD.
    step();
    check("pre rst match", bus.match, 1);
    check("pre rst led", bus.led, 1);
    check("pre rst hit", bus.hit_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst match", bus.match, 0);
    check("async rst led", bus.led, 0);
    check("async rst hit", bus.hit_count, 0);
    drive(0, 0, 0);
    step();
    check("held rst led", bus.led, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 4, 0);
    step();
    check("table reload code4", bus.match, 0);
    drive(1, 13, 0);
    step();
    check("table reload code13", bus.match, 1);
    drive(0, 0, 0);
    step();
    check("post rst hit", bus.hit_count, 1);
    repeat (8) step();
    check("post rst led off", bus.led, 0);

    // in_valid low with in_code toggling or unknown: nothing moves.
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = 1'b0;
      if (c % 2 == 0) bus.in_code = 'x;
      else            bus.in_code = 4'($urandom_range(0, 15));
      step();
      check($sformatf("idle%0d match", c), bus.match, 0);
      check($sformatf("idle%0d led", c), bus.led, 0);
      check($sformatf("idle%0d hit", c), bus.hit_count, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
